fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO; next generation of the team's single-clock 16-bit `fifo`. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. A first-word-fall-through (FWFT) mode can be selected. It sits between producer and consumer datapaths in the same clock domain and replaces fixed-size `fifo` instances.

## Interface
- `DATA_WIDTH`, 16: data bits per word.
- `DEPTH`, 16: number of words; power of two, ≥ 2.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- `AE_LEVEL`, 2: `almost_empty` asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- `FWFT`, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `din`  in  DATA_WIDTH  write data.
- `wr_en`  in  1  write request.
- `rd_en`  in  1  read (pop) request.
- `dout`  out  DATA_WIDTH  read data.
- `dout_valid`  out  1  standard mode: `dout` updated by the previous edge's accepted read; FWFT: equals !empty.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `almost_empty`  out  1  count ≤ AE_LEVEL.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was rejected.
- `underflow`  out  1  sticky: a read was rejected.
- `err_clr`  in  1  clears `overflow` and `underflow` at the next edge.

## Operation
- Storage: DEPTH × DATA_WIDTH register array.
- Pointers `wr_ptr` and `rd_ptr` are ADDR_W+1 bits (ADDR_W = log2 DEPTH). The extra MSB disambiguates full from empty, and the pointers wrap naturally modulo 2·DEPTH.
- Write accepted = `wr_en` && (!full || rd_accepted).
- Read accepted = `rd_en` && !empty.
- Full plus simultaneous wr/rd: both accepted, count unchanged.
- Empty plus simultaneous wr/rd: write accepted, read rejected, `underflow` set; there is no write-through bypass.
- Rejected write: memory, pointers and count unchanged; `overflow` ← 1.
- Rejected read: pointers unchanged; `dout` holds its value; `underflow` ← 1.
- `err_clr` and a new error in the same cycle: the error wins and the flag stays 1.
- Standard mode:
  - `dout` is registered: `dout` ← mem[rd_ptr] on an accepted read.
  - `dout` holds its last value otherwise.
  - `dout_valid` is a one-cycle pulse per accepted read.
- FWFT mode:
  - `dout` = mem[rd_ptr[ADDR_W-1:0]] combinationally while !empty, and 0 while empty.
  - `rd_en` acknowledges the shown word and advances to the next.
- `count`, `full`, `empty`, `almost_full` and `almost_empty` are registered and computed from the next-state count. They are never glitching combinational decodes.
- Reset (`reset` = 0 at an edge) aborts any operation in that cycle:
  - pointers = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0;
  - `dout` = 0, `dout_valid` = 0, `overflow` = 0, `underflow` = 0;
  - memory contents are not cleared.

## Timing
- Write latency: word accepted at edge N; `empty` falls and `count` increments after edge N.
- FWFT: that word appears on `dout` in cycle N+1.
- Standard read latency 1: read accepted at edge N; data valid on `dout` with `dout_valid` = 1 during cycle N+1.
- Sustained throughput: one write and one read per cycle.
- Flags update at the same edge as the `count` change that causes them.
- Errors are visible the cycle after the offending edge.

## Structure
- Shared package `fifo_pkg`:
  - `clog2` function;
  - parameter legality checks (DEPTH power of two, AF/AE ranges);
  - flag-decode constants reusable by future async variants.
- One sub-module `fifo_regfile`: register array with one synchronous write port and one asynchronous read port. The top holds pointers, count, flags and mode logic.
- Bench `test_fifo_param` reuses the existing `clk`/`reset` stimulus style and VCD dump.

## Test plan
Parameters for all scenarios: DATA_WIDTH=16, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
1. Hold reset low 2 cycles, then release → count=0, empty=1, almost_empty=1, full=0, dout=0, no error flags.
2. Write 0x0055..0x005C (8 words) → almost_empty falls at count=3, almost_full rises at count=6, full at count=8. A 9th write sets overflow, count stays 8.
3. Standard mode: read 8 words → dout = 0x0055..0x005C in order, each one cycle after its rd_en with a dout_valid pulse; empty=1 after the last. One extra read sets underflow; dout holds 0x005C.
4. Full, then wr_en=rd_en=1 with din=0x0017 → count stays 8, 0x0017 lands after the wrap, and its later read order is preserved. Also: empty plus wr/rd → count=1, underflow=1.
5. FWFT=1: write 0x00AA → dout=0x00AA the next cycle without rd_en. rd_en pops it; empty=1 and dout=0.
6. Fill 5 words, pulse reset low mid-stream with wr_en=1 → all outputs at reset values the next cycle. err_clr pulse clears sticky flags.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo family: sizing helper, parameter legality
// checks and flag decodes that later async variants can reuse unchanged.
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 16;
    localparam int FIFO_DEF_DEPTH = 16;
    localparam int FIFO_DEF_AE    = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit fifo_params_ok(input int depth, input int af, input int ae);
        return is_pow2(depth) && (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

    // Thresholds are inclusive: almost_full at or above, almost_empty at or below.
    function automatic bit flag_full(input int cnt, input int depth);
        return cnt == depth;
    endfunction

    function automatic bit flag_empty(input int cnt);
        return cnt == 0;
    endfunction

    function automatic bit flag_af(input int cnt, input int lvl);
        return cnt >= lvl;
    endfunction

    function automatic bit flag_ae(input int cnt, input int lvl);
        return cnt <= lvl;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_regfile #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags,
// sticky error flags and optional first-word-fall-through output.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    err_clr
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    if (!fifo_params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [ADDR_W:0]     r_wr_ptr, r_rd_ptr, r_count, w_cnt_nxt;
    logic                r_full, r_empty, r_af, r_ae, r_ovf, r_unf, r_dout_valid;
    logic [DATA_WIDTH-1:0] r_dout, w_rd_data;
    logic                w_rd_acc, w_wr_acc;

    // Handshake: a read pops only when the FIFO holds data; a write is taken
    // when there is room or when a same-cycle pop frees a slot. Requests that
    // are not taken have no effect except raising the matching sticky flag.
    assign w_rd_acc = rd_en && !r_empty;
    assign w_wr_acc = wr_en && (!r_full || w_rd_acc);

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_wr_acc && !w_rd_acc)      w_cnt_nxt = r_count + PTR_ONE;
        else if (!w_wr_acc && w_rd_acc) w_cnt_nxt = r_count - PTR_ONE;
    end

    fifo_regfile #(
        .DW (DATA_WIDTH),
        .AW (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .i_we    (w_wr_acc && reset),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (din),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_af         <= 1'b0;
            r_ae         <= 1'b1;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_dout   <= w_rd_data;
            end
            r_dout_valid <= w_rd_acc;
            // Flags come from the next count so they move on the same edge as count.
            r_count <= w_cnt_nxt;
            r_full  <= flag_full(int'(w_cnt_nxt), DEPTH);
            r_empty <= flag_empty(int'(w_cnt_nxt));
            r_af    <= flag_af(int'(w_cnt_nxt), AF_LEVEL);
            r_ae    <= flag_ae(int'(w_cnt_nxt), AE_LEVEL);
            // A new error beats a simultaneous clear.
            if (wr_en && !w_wr_acc) r_ovf <= 1'b1;
            else if (err_clr)       r_ovf <= 1'b0;
            if (rd_en && !w_rd_acc) r_unf <= 1'b1;
            else if (err_clr)       r_unf <= 1'b0;
        end
    end

    assign dout         = (FWFT != 0) ? (r_empty ? '0 : w_rd_data) : r_dout;
    assign dout_valid   = (FWFT != 0) ? !r_empty : r_dout_valid;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a standard-mode and an FWFT instance share stimulus and
// are compared against a queue model of the FIFO rules.
module tb_fifo_param;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          wr_en, rd_en, err_clr;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_dv, f_dv;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0]    s_count, f_count;

    // clock / reset block
    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .reset(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr)
    );

    fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fw (
        .clk(clk), .reset(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
    );

    // scoreboard / reference model
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_dout;
    logic          m_dv, m_ovf, m_unf;
    int            n_checks = 0;
    int            n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic w, input logic c, input logic [DW-1:0] d, input logic rs);
        bit rd_ok, wr_ok;
        rd_ok = r && (exp_q.size() > 0);
        wr_ok = w && ((exp_q.size() < DEPTH) || rd_ok);
        if (!rs) begin
            exp_q.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            if (rd_ok) m_dout = exp_q.pop_front();
            m_dv = rd_ok;
            if (wr_ok) exp_q.push_back(d);
            if (w && !wr_ok) m_ovf = 1'b1;
            else if (c)      m_ovf = 1'b0;
            if (r && !rd_ok) m_unf = 1'b1;
            else if (c)      m_unf = 1'b0;
        end
    endtask

    task automatic check_all();
        int sz;
        sz = exp_q.size();
        chk("count",        32'(s_count), 32'(sz));
        chk("full",         32'(s_full),  32'(sz == DEPTH));
        chk("empty",        32'(s_empty), 32'(sz == 0));
        chk("almost_full",  32'(s_af),    32'(sz >= AF));
        chk("almost_empty", 32'(s_ae),    32'(sz <= AE));
        chk("overflow",     32'(s_ovf),   32'(m_ovf));
        chk("underflow",    32'(s_unf),   32'(m_unf));
        chk("std_dout",     32'(s_dout),  32'(m_dout));
        chk("std_valid",    32'(s_dv),    32'(m_dv));
        chk("fw_count",     32'(f_count), 32'(sz));
        chk("fw_flags",     {26'd0, f_full, f_empty, f_af, f_ae, f_ovf, f_unf},
                            {26'd0, sz == DEPTH, sz == 0, sz >= AF, sz <= AE, m_ovf, m_unf});
        chk("fw_dout",      32'(f_dout),  (sz > 0) ? 32'(exp_q[0]) : 32'd0);
        chk("fw_valid",     32'(f_dv),    32'(sz > 0));
    endtask

    // driver task: apply one cycle of inputs, advance the model, check outputs
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                        input logic c = 1'b0, input logic rs = 1'b1);
        rst_n   = rs;
        wr_en   = w;
        rd_en   = r;
        din     = d;
        err_clr = c;
        @(posedge clk);
        model_edge(r, w, c, d, rs);
        #1;
        check_all();
    endtask

    initial begin
        exp_q.delete();
        m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0; err_clr = 1'b0;

        // reset held for two edges
        step(0, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0);

        // fill to full, then one rejected write
        for (int i = 0; i < 8; i++) step(1, 0, 16'h0055 + 16'(i));
        step(1, 0, 16'h005D);

        // drain in order, then one rejected read
        for (int i = 0; i < 8; i++) step(0, 1, 16'h0);
        step(0, 1, 16'h0);
        step(0, 0, 16'h0, 1);

        // full with simultaneous write and read, then drain to confirm order
        for (int i = 0; i < 8; i++) step(1, 0, 16'h0010 + 16'(i));
        step(1, 1, 16'h0017);
        for (int i = 0; i < 8; i++) step(0, 1, 16'h0);

        // empty with simultaneous write and read
        step(1, 1, 16'h0033);
        step(0, 1, 16'h0, 1);

        // single word visible in FWFT without a read, then popped
        step(1, 0, 16'h00AA);
        step(0, 0, 16'h0);
        step(0, 1, 16'h0);
        step(0, 0, 16'h0);

        // reset mid-stream with a write pending
        for (int i = 0; i < 5; i++) step(1, 0, 16'h0040 + 16'(i));
        step(1, 0, 16'h0077, 0, 0);
        step(0, 0, 16'h0);

        // error flags set, then cleared; error beats clear in the same cycle
        step(0, 1, 16'h0);
        step(0, 1, 16'h0, 1);
        step(0, 0, 16'h0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 99) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
